// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 panel bus: arbiter FSM states,
// D/C encodings and default sizing parameters.
package ssd1306_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND,
    WAIT,
    GAP
  } arb_state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam int CS_GAP_CYCLES_DEF  = 2;
  localparam int DATA_BURST_MAX_DEF = 16;

endpackage

// File: rtl/ssd1306_bus_arbiter_if.sv
// Bundle of requester, shift-register and panel-control signals around the
// bus arbiter; slave is the arbiter's view, master the surrounding logic.
interface ssd1306_bus_arbiter_if;
  import ssd1306_pkg::*;

  logic  cmd_req;
  byte_t cmd_byte;
  logic  cmd_last;
  logic  cmd_ack;
  logic  dat_req;
  byte_t dat_byte;
  logic  dat_last;
  logic  dat_ack;
  logic  sr_start;
  byte_t sr_byte;
  logic  sr_ready;
  logic  oled_csn;
  logic  oled_dc;
  logic  busy;
  logic  grant_cmd;

  modport slave (
    input  cmd_req, cmd_byte, cmd_last, dat_req, dat_byte, dat_last, sr_ready,
    output cmd_ack, dat_ack, sr_start, sr_byte, oled_csn, oled_dc, busy, grant_cmd
  );

  modport master (
    output cmd_req, cmd_byte, cmd_last, dat_req, dat_byte, dat_last, sr_ready,
    input  cmd_ack, dat_ack, sr_start, sr_byte, oled_csn, oled_dc, busy, grant_cmd
  );

endinterface

// File: rtl/ssd1306_bus_arbiter.sv
// Arbitrates command and pixel-data byte streams onto one SPI shift register,
// framing each group with chip select and a fixed CS-high gap.
module ssd1306_bus_arbiter
  import ssd1306_pkg::*;
#(
  parameter int CS_GAP_CYCLES  = CS_GAP_CYCLES_DEF,
  parameter int DATA_BURST_MAX = DATA_BURST_MAX_DEF
) (
  input logic                  clk_in,
  input logic                  reset,
  ssd1306_bus_arbiter_if.slave bus
);

  localparam logic [7:0] GAP_LAST    = 8'(CS_GAP_CYCLES - 1);
  localparam logic [7:0] BURST_LIMIT = 8'(DATA_BURST_MAX);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_grant_cmd;
  logic       r_last;
  logic       r_wait_armed;
  logic [7:0] r_burst_cnt;
  logic [7:0] r_gap_cnt;

  logic       w_req;
  logic       w_last_in;
  logic       w_accept;
  logic       w_burst_full;
  byte_t      w_byte;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_req        = r_grant_cmd ? bus.cmd_req  : bus.dat_req;
    w_byte       = r_grant_cmd ? bus.cmd_byte : bus.dat_byte;
    w_last_in    = r_grant_cmd ? bus.cmd_last : bus.dat_last;
    w_burst_full = !r_grant_cmd && (r_burst_cnt >= BURST_LIMIT);
    w_accept     = 1'b0;
    w_next       = r_state;

    case (r_state)
      IDLE:  if (bus.cmd_req || bus.dat_req) w_next = SETUP;
      SETUP: w_next = SEND;
      SEND: begin
        if (!w_req) begin
          w_next = GAP;
        end else if (bus.sr_ready) begin
          w_accept = 1'b1;
          w_next   = WAIT;
        end
      end
      // sr_ready is still stale in the first WAIT cycle, hence the arm flag.
      WAIT: begin
        if (r_wait_armed && bus.sr_ready) begin
          w_next = (r_last || w_burst_full) ? GAP : SEND;
        end
      end
      GAP:     if (r_gap_cnt == GAP_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase

    // A byte presented while reset is asserted is abandoned, never acked.
    if (reset) begin
      w_accept = 1'b0;
      w_next   = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_grant_cmd  <= 1'b0;
      r_last       <= 1'b0;
      r_wait_armed <= 1'b0;
      r_burst_cnt  <= 8'd0;
      r_gap_cnt    <= 8'd0;
    end else begin
      r_wait_armed <= (r_state == WAIT);
      r_gap_cnt    <= (r_state == GAP) ? r_gap_cnt + 8'd1 : 8'd0;

      if (r_state == IDLE) begin
        r_burst_cnt <= 8'd0;
        if (bus.cmd_req || bus.dat_req) r_grant_cmd <= bus.cmd_req;
      end

      if (w_accept) begin
        r_last <= w_last_in;
        if (!r_grant_cmd && (r_burst_cnt < BURST_LIMIT)) r_burst_cnt <= r_burst_cnt + 8'd1;
      end
    end
  end

  assign bus.sr_start  = w_accept;
  assign bus.sr_byte   = w_accept ? w_byte : 8'h00;
  assign bus.cmd_ack   = w_accept && r_grant_cmd;
  assign bus.dat_ack   = w_accept && !r_grant_cmd;
  assign bus.oled_csn  = !((r_state == SETUP) || (r_state == SEND) || (r_state == WAIT));
  assign bus.oled_dc   = ((r_state == IDLE) || r_grant_cmd) ? DC_CMD : DC_DATA;
  assign bus.busy      = (r_state != IDLE);
  assign bus.grant_cmd = r_grant_cmd;

endmodule
